l_debounce_monitor: RTL and testbench
=====================================

Name: l_debounce_monitor

Overview:
- Downstream consumer of the 3-input decoder's single-bit output L.
- Registers L and filters out glitches shorter than DEBOUNCE cycles, then publishes a stable level.
- Emits one-cycle rise/fall pulses and keeps a saturating count of qualified rising edges.
- Sits between the combinational decoder and any control logic that needs a clean, event-counted L.

Parameters:
DEBOUNCE, 3, consecutive identical samples required to accept a level change; legal range 2..15
CNT_W, 8, width of the rising-edge event counter

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
l_in  input  1  raw decoder output L; synchronous to clk
clr  input  1  synchronous clear of rise_cnt and cnt_sat
l_stable  output  1  debounced level of l_in
rise_pulse  output  1  one-cycle pulse on accepted 0->1 transition
fall_pulse  output  1  one-cycle pulse on accepted 1->0 transition
rise_cnt  output  CNT_W  saturating count of accepted rising edges
cnt_sat  output  1  sticky; high once rise_cnt has reached its maximum value

Behaviour:
- Interface fixed: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): l_q=0, state=S_LOW, stab_cnt=0, l_stable=0, rise_pulse=0, fall_pulse=0, rise_cnt=0, cnt_sat=0. Reset overrides clr and all FSM activity.
- Input stage: l_q <= l_in every edge. The FSM sees only l_q.
- stab_cnt width: 4 bits, enough for DEBOUNCE up to 15.
- FSM states: S_LOW, S_L2H, S_HIGH, S_H2L.
- S_LOW, l_q=1: go to S_L2H with stab_cnt=1. Otherwise stay in S_LOW.
- S_L2H:
  - l_q=0: go to S_LOW with stab_cnt=0. Glitch rejected; no pulse.
  - l_q=1 and stab_cnt==DEBOUNCE-1: go to S_HIGH, l_stable<=1, rise_pulse<=1.
  - Otherwise: stab_cnt++.
- S_HIGH and S_H2L mirror S_LOW and S_L2H with the polarity swapped. The accepted transition sets l_stable<=0 and fall_pulse<=1.
- Latency: l_in captured into l_q at edge k and held through edge k+DEBOUNCE-1. Then l_stable changes at edge k+DEBOUNCE. Only DEBOUNCE consecutive identical samples are accepted.
- Pulses:
  - rise_pulse and fall_pulse are registered and high for exactly one cycle.
  - They are never high together.
  - Back-to-back accepted edges are at least DEBOUNCE cycles apart.
- Counter:
  - On rise_pulse generation, rise_cnt increments unless it equals 2^CNT_W-1. It never wraps.
  - cnt_sat<=1 on the same edge at which rise_cnt becomes 2^CNT_W-1. It stays high until clr or reset.
  - clr=1 sets rise_cnt=0 and cnt_sat=0.
  - clr=1 in the same cycle as an accepted rise sets rise_cnt=1 and cnt_sat=0 (clear, then count).
- Reset mid-debounce: the pending transition is discarded. No pulse is issued and state returns to S_LOW.
- The FSM is unaffected by clr.

Decomposition:
- Shared package l_mon_pkg holds:
  - typedef enum logic [1:0] l_mon_state_t {S_LOW, S_L2H, S_HIGH, S_H2L}
  - localparam STAB_W = 4
- One sub-module: sat_counter (parameter CNT_W; ports clk, rst_n, clr, inc, cnt, sat), implementing the counter rules above.

Test Plan:
All scenarios use DEBOUNCE=3 and CNT_W=8.
- Reset: hold rst_n=0 for 3 edges with l_in=1 and clr=0 -> all outputs 0. After release with l_in still 1, l_stable=1 at the 4th edge after release.
- Clean rise: l_in 0->1 captured at edge 10 and held -> l_stable=1 and rise_pulse=1 after edge 13. rise_pulse=0 after edge 14. rise_cnt=1.
- Glitch reject: l_in=1 for exactly 2 cycles, then 0 -> l_stable stays 0, no pulses, rise_cnt unchanged. Repeat for a 2-cycle low glitch while stable high -> l_stable stays 1, no fall_pulse.
- Fall: from stable high, l_in=0 held 3 samples -> fall_pulse exactly one cycle and l_stable=0 on the same edge. rise_cnt unchanged.
- Saturation: 256 clean rise/fall cycles (l_in toggled every 8 cycles) -> rise_cnt stops at 255. cnt_sat=1 on the edge rise_cnt reaches 255 and stays high. The 256th rise still pulses but the count holds at 255.
- clr collision and mid-debounce reset:
  - clr=1 on the edge an accepted rise is generated, with rise_cnt=5 -> rise_cnt=1, cnt_sat=0.
  - rst_n=0 while in S_L2H with stab_cnt=2 -> no rise_pulse; state S_LOW; rise_cnt=0.

Source files
------------

// File: rtl/l_mon_pkg.sv
// Shared types and constants for the L debounce monitor.
package l_mon_pkg;

  localparam int unsigned STAB_W = 4;

  typedef enum logic [1:0] {
    S_LOW,
    S_L2H,
    S_HIGH,
    S_H2L
  } l_mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             sat_d, sat_q;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      // Clear wins, but a same-cycle increment still counts once.
      cnt_d = inc ? CNT_W'(1) : '0;
      sat_d = 1'b0;
    end else if (inc && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CntMax) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/l_debounce_monitor.sv
// Registers the decoder output L, debounces it, and reports edge pulses plus
// a saturating count of accepted rising edges.
module l_debounce_monitor
  import l_mon_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             l_in,
  input  logic             clr,
  output logic             l_stable,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             cnt_sat
);

  localparam logic [STAB_W-1:0] StabLast = STAB_W'(DEBOUNCE - 1);

  logic              l_q;
  l_mon_state_t      state_d, state_q;
  logic [STAB_W-1:0] stab_cnt_d, stab_cnt_q;
  logic              l_stable_d, l_stable_q;
  logic              rise_d, rise_q;
  logic              fall_d, fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_q        <= 1'b0;
      state_q    <= S_LOW;
      stab_cnt_q <= '0;
      l_stable_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      l_q        <= l_in;
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      l_stable_q <= l_stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (l_q) begin
          state_d    = S_L2H;
          stab_cnt_d = STAB_W'(1);
        end
      end
      S_L2H: begin
        if (!l_q) begin
          state_d    = S_LOW;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == StabLast) begin
          state_d    = S_HIGH;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!l_q) begin
          state_d    = S_H2L;
          stab_cnt_d = STAB_W'(1);
        end
      end
      S_H2L: begin
        if (l_q) begin
          state_d    = S_HIGH;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == StabLast) begin
          state_d    = S_LOW;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = S_LOW;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Pulses are decided one cycle early so they register with l_stable.
  always_comb begin
    rise_d     = (state_q == S_L2H) && l_q && (stab_cnt_q == StabLast);
    fall_d     = (state_q == S_H2L) && !l_q && (stab_cnt_q == StabLast);
    l_stable_d = l_stable_q;
    if (rise_d) begin
      l_stable_d = 1'b1;
    end else if (fall_d) begin
      l_stable_d = 1'b0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_rise_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (rise_d),
    .cnt   (rise_cnt),
    .sat   (cnt_sat)
  );

  assign l_stable   = l_stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_l_debounce_monitor.sv
// Bench for l_debounce_monitor: fixed vector table, directed corner cases and
// random stimulus against a run-length reference model.
module tb_l_debounce_monitor;

  localparam int unsigned DEBOUNCE = 3;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             l_in = 1'b0;
  logic             clr = 1'b0;
  logic             l_stable;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_cnt;
  logic             cnt_sat;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic        m_lq = 1'b0;
  logic        m_stable = 1'b0;
  int unsigned m_run = 0;
  logic        m_rise = 1'b0;
  logic        m_fall = 1'b0;
  int unsigned m_cnt = 0;
  logic        m_sat = 1'b0;

  l_debounce_monitor #(
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .l_in       (l_in),
    .clr        (clr),
    .l_stable   (l_stable),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_cnt   (rise_cnt),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       l_in;
    logic       clr;
    logic       stable;
    logic       rise;
    logic       fall;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl [0:28];

  function automatic vec_t mk(input logic r, input logic l, input logic c, input logic s,
                              input logic ri, input logic fa, input logic [7:0] n);
    vec_t v;
    v.rst_n = r; v.l_in = l; v.clr = c; v.stable = s; v.rise = ri; v.fall = fa; v.cnt = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // A level is accepted once DEBOUNCE consecutive registered samples disagree with it.
  task automatic model_update(input logic r, input logic l, input logic c);
    logic obs;
    if (!r) begin
      m_lq = 0; m_stable = 0; m_run = 0; m_rise = 0; m_fall = 0; m_cnt = 0; m_sat = 0;
    end else begin
      obs    = m_lq;
      m_lq   = l;
      m_rise = 0;
      m_fall = 0;
      if (obs != m_stable) begin
        m_run++;
        if (m_run == DEBOUNCE) begin
          m_stable = obs;
          m_rise   = obs;
          m_fall   = !obs;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
      if (c) begin
        m_cnt = m_rise ? 1 : 0;
        m_sat = 0;
      end else if (m_rise && m_cnt < CNT_MAX) begin
        m_cnt++;
        if (m_cnt == CNT_MAX) m_sat = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic c);
    rst_n = r;
    l_in  = l;
    clr   = c;
    @(posedge clk);
    model_update(r, l, c);
    #1;
    chk("model_l_stable", l_stable, m_stable);
    chk("model_rise_pulse", rise_pulse, m_rise);
    chk("model_fall_pulse", fall_pulse, m_fall);
    chk("model_rise_cnt", rise_cnt, m_cnt);
    chk("model_cnt_sat", cnt_sat, m_sat);
    chk("pulse_exclusive", rise_pulse & fall_pulse, 0);
  endtask

  task automatic hold(input logic l, input int n);
    for (int i = 0; i < n; i++) step(1'b1, l, 1'b0);
  endtask

  int rises_seen;
  int hold_len;
  logic rv;

  initial begin
    // rst, l, clr -> stable, rise, fall, cnt
    tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 1, 1, 0, 1);
    tbl[7]  = mk(1, 1, 0, 1, 0, 0, 1);
    tbl[8]  = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[10] = mk(1, 1, 0, 1, 0, 0, 1);
    tbl[11] = mk(1, 1, 0, 1, 0, 0, 1);
    tbl[12] = mk(1, 1, 0, 1, 0, 0, 1);
    tbl[13] = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[14] = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[15] = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 1);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[18] = mk(1, 1, 0, 0, 0, 0, 1);
    tbl[19] = mk(1, 1, 0, 0, 0, 0, 1);
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[22] = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[23] = mk(1, 0, 1, 0, 0, 0, 0);
    tbl[24] = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[25] = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[26] = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[27] = mk(1, 1, 1, 1, 1, 0, 1);
    tbl[28] = mk(1, 1, 0, 1, 0, 0, 1);

    for (int i = 0; i <= 28; i++) begin
      step(tbl[i].rst_n, tbl[i].l_in, tbl[i].clr);
      chk("tbl_l_stable", l_stable, tbl[i].stable);
      chk("tbl_rise_pulse", rise_pulse, tbl[i].rise);
      chk("tbl_fall_pulse", fall_pulse, tbl[i].fall);
      chk("tbl_rise_cnt", rise_cnt, tbl[i].cnt);
      chk("tbl_cnt_sat", cnt_sat, 0);
    end

    // clr colliding with an accepted rise while rise_cnt == 5
    hold(1'b0, 6);
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 6);
      hold(1'b0, 6);
    end
    chk("cnt_before_clr", rise_cnt, 5);
    hold(1'b1, 3);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_collide_rise", rise_pulse, 1);
    chk("clr_collide_cnt", rise_cnt, 1);
    chk("clr_collide_sat", cnt_sat, 0);

    // Reset while in S_L2H with stab_cnt == 2
    hold(1'b0, 6);
    hold(1'b1, 3);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_mid_rise", rise_pulse, 0);
    chk("rst_mid_stable", l_stable, 0);
    chk("rst_mid_cnt", rise_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("rst_mid_no_early_rise", rise_pulse, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("rst_mid_full_debounce", rise_pulse, 1);

    // Saturation over 256 clean rise/fall cycles
    step(1'b0, 1'b0, 1'b0);
    rises_seen = 0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 16; j++) begin
        step(1'b1, (j < 8), 1'b0);
        if (rise_pulse) rises_seen++;
        if (rise_cnt == CNT_W'(CNT_MAX)) chk("sat_with_max", cnt_sat, 1);
        else chk("sat_below_max", cnt_sat, 0);
      end
    end
    chk("sat_rises_seen", rises_seen, 256);
    chk("sat_cnt", rise_cnt, CNT_MAX);
    chk("sat_flag", cnt_sat, 1);
    step(1'b1, 1'b0, 1'b1);
    chk("sat_clr_cnt", rise_cnt, 0);
    chk("sat_clr_flag", cnt_sat, 0);

    // Random runs of random length, with occasional clr and reset
    for (int i = 0; i < 1500; i++) begin
      hold_len = $urandom_range(1, 6);
      rv = 1'($urandom_range(0, 1));
      for (int j = 0; j < hold_len; j++) begin
        step(($urandom_range(0, 299) != 0), rv, ($urandom_range(0, 49) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
